memory_dp: RTL and testbench
============================

Name: memory_dp

Overview:
- Parametrised simple dual-port synchronous RAM; next generation of the team's 8x256 byte memory.
- Adds width/depth parameters, per-byte write enables, a registered read with a valid strobe, a selectable read-during-write policy, and a hardware clear sequence after reset.
- Sits between datapath producers and consumers as general scratch/buffer storage.
- One write port and one read port, both in the clk domain.

Parameters:
- DATA_WIDTH, 8, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 8, address bus width.
- MEM_SIZE, 256, number of words; must be <= 2**ADDR_WIDTH.
- RD_MODE, 0, read-during-write policy for the same address: 0 = read-first (old data), 1 = write-first (bypass new data).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- init_busy  out  1  high while the post-reset clear sequence runs.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.
- wr_be  in  DATA_WIDTH/8  byte enables; bit i covers wr_data[8i+7:8i].
- rd_en  in  1  read request.
- rd_addr  in  ADDR_WIDTH  read address.
- rd_data  out  DATA_WIDTH  registered read data.
- rd_valid  out  1  one-cycle strobe marking rd_data valid.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: rd_data=0, rd_valid=0, init_busy=1, FSM=INIT, clear counter=0.
- FSM INIT:
  - Each cycle writes 0 to mem[counter], then counter increments.
  - After the write to MEM_SIZE-1, move to READY and drop init_busy on the next cycle edge.
  - Clear takes exactly MEM_SIZE cycles after rst deasserts.
- FSM READY: normal operation; no exit except rst.
- Requests during INIT: wr_en and rd_en are ignored. No memory update, rd_valid stays 0, rd_data stays 0.
- Write: on a clk edge with wr_en=1 in READY, update only the byte lanes whose wr_be bit is 1. wr_be=0 means no write.
- Read latency is 1 cycle: rd_en=1 at edge N gives rd_data/rd_valid after edge N+1. rd_valid is high for exactly one cycle per accepted read.
- rd_en=0: rd_valid=0 and rd_data holds its previous value.
- Back-to-back reads: one result per cycle; full throughput, no bubbles.
- Read and write to the same address in the same cycle:
  - RD_MODE=0: rd_data returns the pre-write contents.
  - RD_MODE=1: rd_data returns the byte-wise merge — new bytes where wr_be=1, old bytes elsewhere.
- Different addresses in the same cycle: independent, no interaction.
- Out-of-range address (addr >= MEM_SIZE):
  - Write is dropped.
  - Read returns 0 with rd_valid=1.
- rst asserted mid-operation:
  - Next edge applies the reset values.
  - Any in-flight read is discarded (rd_valid=0).
  - Clear restarts from address 0.
- Memory contents are never X after init_busy falls.

Optional Feature:
- Macro MEMORY_DP_PARITY_EN.
- Defined:
  - Store one even-parity bit per byte lane.
  - Clear writes parity 0.
  - Add output rd_parity_err (DATA_WIDTH/8 bits), aligned with rd_data/rd_valid, reset 0. A bit is set when the stored byte and its parity mismatch.
  - Bypassed data in RD_MODE=1 uses freshly computed parity, so it never flags.
  - Out-of-range reads flag 0.
- Undefined: no parity storage and no rd_parity_err port; behaviour otherwise identical.

Decomposition:
- Package memory_pkg holds:
  - FSM state typedef {INIT, READY};
  - RD_MODE constants RD_FIRST=0, WR_FIRST=1;
  - function byte_parity().
- One natural sub-module: memory_dp_init_ctrl, the INIT/READY FSM plus clear counter. It drives the internal clear write port and init_busy; top-level muxes clear vs user write.

Test Plan:
- Reset clear: DATA_WIDTH=8, MEM_SIZE=256, rst high 2 cycles then low -> init_busy high exactly 256 cycles; then reading addr 0..255 gives 0x00 with rd_valid.
- Basic RW: write 0x55@0, 0xAA@1 (wr_be=1); read 0 then 1 back-to-back -> rd_data 0x55 then 0xAA on consecutive cycles, rd_valid 1 both cycles.
- Byte enables: DATA_WIDTH=32, write 0x11223344 be=0xF, then 0xAABBCCDD be=0x5 -> read 0x11BB33DD.
- Collision: mem[5]=0x12, same cycle write 0x34@5 and read 5 -> RD_MODE=0 gives 0x12, RD_MODE=1 gives 0x34; next read gives 0x34.
- INIT and mid-reset:
  - Writes/reads during init_busy -> no rd_valid; memory unchanged after clear.
  - rst pulse one cycle after issuing a read -> rd_valid stays 0, init_busy re-rises, clear restarts.
- Range/parity:
  - MEM_SIZE=200, read addr 210 -> rd_data 0, rd_valid 1.
  - With MEMORY_DP_PARITY_EN, force-flip a stored data bit at addr 3 -> rd_parity_err=1 on the read.

Source files
------------

// File: rtl/memory_dp_pkg.sv
// Shared types and helpers for the memory_dp slice.
package memory_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  localparam int unsigned RD_FIRST = 0;
  localparam int unsigned WR_FIRST = 1;

  // Even parity: the stored bit makes the total count of ones even.
  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/memory_dp_init_ctrl.sv
// Post-reset clear sequencer: walks every address once, writing zero,
// then parks in READY until the next reset.
module memory_dp_init_ctrl
  import memory_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned MEM_SIZE   = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  init_busy,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_SIZE - 1);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;

  // State and clear-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and clear-port outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    init_busy = 1'b0;
    clr_we    = 1'b0;
    clr_addr  = cnt_q;
    unique case (state_q)
      INIT: begin
        init_busy = 1'b1;
        clr_we    = ~rst;
        if (cnt_q == LAST_ADDR) begin
          state_d = READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      READY: begin
        state_d = READY;
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

endmodule

// File: rtl/memory_dp.sv
// Simple dual-port synchronous RAM with byte enables, registered read,
// selectable read-during-write policy and hardware clear after reset.
// Optional per-byte parity: define MEMORY_DP_PARITY_EN.
module memory_dp
  import memory_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned MEM_SIZE   = 256,
  parameter int unsigned RD_MODE    = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    init_busy,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid
`ifdef MEMORY_DP_PARITY_EN
  ,
  output logic [DATA_WIDTH/8-1:0] rd_parity_err
`endif
);

  localparam int unsigned NB = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [MEM_SIZE];
`ifdef MEMORY_DP_PARITY_EN
  logic [NB-1:0]         mem_par [MEM_SIZE];
  logic [NB-1:0]         rd_perr_d;
`endif

  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  ready;
  logic                  wr_in_range;
  logic                  rd_in_range;
  logic                  user_we;
  logic                  collide;
  logic [ADDR_WIDTH-1:0] wa;
  logic [DATA_WIDTH-1:0] wd;
  logic [NB-1:0]         lane_we;
  logic [DATA_WIDTH-1:0] rd_word;

  memory_dp_init_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .MEM_SIZE   (MEM_SIZE)
  ) u_init_ctrl (
    .clk       (clk),
    .rst       (rst),
    .init_busy (init_busy),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr)
  );

  assign ready       = ~init_busy;
  assign wr_in_range = (32'(wr_addr) < MEM_SIZE);
  assign rd_in_range = (32'(rd_addr) < MEM_SIZE);
  assign user_we     = ready & wr_en & wr_in_range & (|wr_be);
  assign collide     = (RD_MODE == WR_FIRST) && user_we && (wr_addr == rd_addr);

  // Single physical write port: the clear sequence owns it during INIT.
  always_comb begin
    wa      = wr_addr;
    wd      = wr_data;
    lane_we = '0;
    if (clr_we) begin
      wa      = clr_addr;
      wd      = '0;
      lane_we = '1;
    end else if (user_we) begin
      lane_we = wr_be;
    end
  end

  // Byte-lane memory update.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NB; i++) begin
      if (lane_we[i]) begin
        mem[wa][8*i +: 8] <= wd[8*i +: 8];
`ifdef MEMORY_DP_PARITY_EN
        mem_par[wa][i] <= byte_parity(wd[8*i +: 8]);
`endif
      end
    end
  end

  // Read word selection, including write-first byte merge on collision.
  always_comb begin
    rd_word = '0;
`ifdef MEMORY_DP_PARITY_EN
    rd_perr_d = '0;
`endif
    if (rd_in_range) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (collide && wr_be[i]) begin
          rd_word[8*i +: 8] = wr_data[8*i +: 8];
        end else begin
          rd_word[8*i +: 8] = mem[rd_addr][8*i +: 8];
`ifdef MEMORY_DP_PARITY_EN
          rd_perr_d[i] = byte_parity(mem[rd_addr][8*i +: 8]) ^ mem_par[rd_addr][i];
`endif
        end
      end
    end
  end

  // Registered read output; data holds when no read is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
`ifdef MEMORY_DP_PARITY_EN
      rd_parity_err <= '0;
`endif
    end else if (ready && rd_en) begin
      rd_data  <= rd_word;
      rd_valid <= 1'b1;
`ifdef MEMORY_DP_PARITY_EN
      rd_parity_err <= rd_perr_d;
`endif
    end else begin
      rd_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_memory_dp.sv
// Directed bench for memory_dp: an 8-bit read-first instance and a
// 32-bit write-first instance with a partial address space.
module tb_memory_dp;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // 8-bit, 256 words, read-first
  logic        busy8;
  logic        w8_en;
  logic [7:0]  w8_addr;
  logic [7:0]  w8_data;
  logic [0:0]  w8_be;
  logic        r8_en;
  logic [7:0]  r8_addr;
  logic [7:0]  r8_data;
  logic        r8_valid;

  // 32-bit, 200 words, write-first
  logic        busy32;
  logic        w32_en;
  logic [7:0]  w32_addr;
  logic [31:0] w32_data;
  logic [3:0]  w32_be;
  logic        r32_en;
  logic [7:0]  r32_addr;
  logic [31:0] r32_data;
  logic        r32_valid;

`ifdef MEMORY_DP_PARITY_EN
  logic [0:0]  r8_perr;
  logic [3:0]  r32_perr;
`endif

  memory_dp #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (8),
    .MEM_SIZE   (256),
    .RD_MODE    (0)
  ) u8 (
    .clk       (clk),
    .rst       (rst),
    .init_busy (busy8),
    .wr_en     (w8_en),
    .wr_addr   (w8_addr),
    .wr_data   (w8_data),
    .wr_be     (w8_be),
    .rd_en     (r8_en),
    .rd_addr   (r8_addr),
    .rd_data   (r8_data),
    .rd_valid  (r8_valid)
`ifdef MEMORY_DP_PARITY_EN
    ,
    .rd_parity_err (r8_perr)
`endif
  );

  memory_dp #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (8),
    .MEM_SIZE   (200),
    .RD_MODE    (1)
  ) u32 (
    .clk       (clk),
    .rst       (rst),
    .init_busy (busy32),
    .wr_en     (w32_en),
    .wr_addr   (w32_addr),
    .wr_data   (w32_data),
    .wr_be     (w32_be),
    .rd_en     (r32_en),
    .rd_addr   (r32_addr),
    .rd_data   (r32_data),
    .rd_valid  (r32_valid)
`ifdef MEMORY_DP_PARITY_EN
    ,
    .rd_parity_err (r32_perr)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    w8_en  = 1'b0; w8_addr  = '0; w8_data  = '0; w8_be  = 1'b1;
    r8_en  = 1'b0; r8_addr  = '0;
    w32_en = 1'b0; w32_addr = '0; w32_data = '0; w32_be = 4'hF;
    r32_en = 1'b0; r32_addr = '0;
  endtask

  task automatic test_reset();
    int n;
    int n32;
    int bad;
    rst = 1'b1;
    idle();
    tick();
    tick();
    checks++;
    if (busy8 !== 1'b1 || busy32 !== 1'b1) begin
      failures++;
      $display("FAIL reset_busy: got busy8=%b busy32=%b, want 1 1", busy8, busy32);
    end
    checks++;
    if (r8_valid !== 1'b0 || r8_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_rd8: got valid=%b data=%h, want 0 00", r8_valid, r8_data);
    end
    checks++;
    if (r32_valid !== 1'b0 || r32_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_rd32: got valid=%b data=%h, want 0 0", r32_valid, r32_data);
    end
    rst = 1'b0;
    n   = 0;
    n32 = 0;
    bad = 0;
    do begin
      if (n < 100) begin
        w8_en  = 1'b1; w8_addr  = 8'(n); w8_data  = 8'hFF;
        r8_en  = 1'b1; r8_addr  = 8'(n);
        w32_en = 1'b1; w32_addr = 8'(n); w32_data = 32'hFFFF_FFFF; w32_be = 4'hF;
        r32_en = 1'b1; r32_addr = 8'(n);
      end else begin
        idle();
      end
      tick();
      n++;
      if (n <= 100 && (r8_valid !== 1'b0 || r32_valid !== 1'b0)) bad++;
      if (busy32 === 1'b0 && n32 == 0) n32 = n;
    end while (busy8 === 1'b1 && n < 1000);
    idle();
    checks++;
    if (n != 256) begin
      failures++;
      $display("FAIL init_len8: got %0d cycles busy, want 256", n);
    end
    checks++;
    if (n32 != 200) begin
      failures++;
      $display("FAIL init_len32: got %0d cycles busy, want 200", n32);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL init_reqs_ignored: got %0d rd_valid pulses during init, want 0", bad);
    end
  endtask

  task automatic test_clear_readback();
    for (int i = 0; i < 256; i++) begin
      r8_en = 1'b1; r8_addr = 8'(i);
      r32_en = (i < 200); r32_addr = 8'(i);
      tick();
      checks++;
      if (r8_valid !== 1'b1 || r8_data !== 8'h00) begin
        failures++;
        $display("FAIL clear8[%0d]: got valid=%b data=%h, want 1 00", i, r8_valid, r8_data);
      end
      if (i < 200) begin
        checks++;
        if (r32_valid !== 1'b1 || r32_data !== 32'h0) begin
          failures++;
          $display("FAIL clear32[%0d]: got valid=%b data=%h, want 1 0", i, r32_valid, r32_data);
        end
      end
    end
    idle();
  endtask

  task automatic test_basic_rw();
    w8_en = 1'b1; w8_addr = 8'd0; w8_data = 8'h55; tick();
    w8_addr = 8'd1; w8_data = 8'hAA; tick();
    w8_en = 1'b0;
    r8_en = 1'b1; r8_addr = 8'd0; tick();
    checks++;
    if (r8_valid !== 1'b1 || r8_data !== 8'h55) begin
      failures++;
      $display("FAIL basic_rd0: got valid=%b data=%h, want 1 55", r8_valid, r8_data);
    end
    r8_addr = 8'd1; tick();
    checks++;
    if (r8_valid !== 1'b1 || r8_data !== 8'hAA) begin
      failures++;
      $display("FAIL basic_rd1: got valid=%b data=%h, want 1 aa", r8_valid, r8_data);
    end
    r8_en = 1'b0; tick();
    checks++;
    if (r8_valid !== 1'b0 || r8_data !== 8'hAA) begin
      failures++;
      $display("FAIL basic_hold: got valid=%b data=%h, want 0 aa", r8_valid, r8_data);
    end
    idle();
  endtask

  task automatic test_byte_enables();
    w32_en = 1'b1; w32_addr = 8'd10; w32_data = 32'h1122_3344; w32_be = 4'hF; tick();
    w32_data = 32'hAABB_CCDD; w32_be = 4'h5; tick();
    w32_data = 32'hFFFF_FFFF; w32_be = 4'h0; tick();
    w32_en = 1'b0;
    r32_en = 1'b1; r32_addr = 8'd10; tick();
    checks++;
    if (r32_valid !== 1'b1 || r32_data !== 32'h11BB_33DD) begin
      failures++;
      $display("FAIL byte_en: got valid=%b data=%h, want 1 11bb33dd", r32_valid, r32_data);
    end
    idle();
  endtask

  task automatic test_collision();
    w8_en = 1'b1; w8_addr = 8'd5; w8_data = 8'h12;
    w32_en = 1'b1; w32_addr = 8'd5; w32_data = 32'h12; w32_be = 4'hF;
    tick();
    w8_data = 8'h34; r8_en = 1'b1; r8_addr = 8'd5;
    w32_data = 32'h34; r32_en = 1'b1; r32_addr = 8'd5;
    tick();
    checks++;
    if (r8_valid !== 1'b1 || r8_data !== 8'h12) begin
      failures++;
      $display("FAIL coll_rdfirst: got valid=%b data=%h, want 1 12", r8_valid, r8_data);
    end
    checks++;
    if (r32_valid !== 1'b1 || r32_data !== 32'h34) begin
      failures++;
      $display("FAIL coll_wrfirst: got valid=%b data=%h, want 1 34", r32_valid, r32_data);
    end
    w8_addr = 8'd6; w8_data = 8'h77;
    w32_en = 1'b0;
    tick();
    checks++;
    if (r8_data !== 8'h34) begin
      failures++;
      $display("FAIL coll_after8: got %h, want 34", r8_data);
    end
    checks++;
    if (r32_data !== 32'h34) begin
      failures++;
      $display("FAIL coll_after32: got %h, want 34", r32_data);
    end
    w8_en = 1'b0; r8_addr = 8'd6;
    w32_en = 1'b1; w32_data = 32'hAABB_CCDD; w32_be = 4'h2;
    tick();
    checks++;
    if (r8_data !== 8'h77) begin
      failures++;
      $display("FAIL diff_addr8: got %h, want 77", r8_data);
    end
    checks++;
    if (r32_data !== 32'h0000_CC34) begin
      failures++;
      $display("FAIL coll_merge: got %h, want 0000cc34", r32_data);
    end
    w32_en = 1'b0;
    tick();
    checks++;
    if (r32_data !== 32'h0000_CC34) begin
      failures++;
      $display("FAIL merge_after: got %h, want 0000cc34", r32_data);
    end
    idle();
  endtask

  task automatic test_out_of_range();
    w32_en = 1'b1; w32_addr = 8'd210; w32_data = 32'hDEAD_BEEF; w32_be = 4'hF; tick();
    w32_addr = 8'd199; w32_data = 32'h0102_0304; tick();
    w32_en = 1'b0;
    r32_en = 1'b1; r32_addr = 8'd210; tick();
    checks++;
    if (r32_valid !== 1'b1 || r32_data !== 32'h0) begin
      failures++;
      $display("FAIL oor_rd210: got valid=%b data=%h, want 1 0", r32_valid, r32_data);
    end
    r32_addr = 8'd199; tick();
    checks++;
    if (r32_valid !== 1'b1 || r32_data !== 32'h0102_0304) begin
      failures++;
      $display("FAIL last_rd199: got valid=%b data=%h, want 1 01020304", r32_valid, r32_data);
    end
    r32_addr = 8'd200; tick();
    checks++;
    if (r32_valid !== 1'b1 || r32_data !== 32'h0) begin
      failures++;
      $display("FAIL oor_rd200: got valid=%b data=%h, want 1 0", r32_valid, r32_data);
    end
    idle();
  endtask

`ifdef MEMORY_DP_PARITY_EN
  task automatic test_parity();
    w8_en = 1'b1; w8_addr = 8'd3; w8_data = 8'h07; tick();
    w8_en = 1'b0; r8_en = 1'b1; r8_addr = 8'd3; tick();
    checks++;
    if (r8_data !== 8'h07 || r8_perr !== 1'b0) begin
      failures++;
      $display("FAIL parity_clean: got data=%h perr=%b, want 07 0", r8_data, r8_perr);
    end
    idle();
  endtask
`endif

  task automatic test_mid_reset();
    int n;
    r8_en = 1'b1; r8_addr = 8'd0;
    rst = 1'b1;
    tick();
    checks++;
    if (r8_valid !== 1'b0 || r8_data !== 8'h00 || busy8 !== 1'b1) begin
      failures++;
      $display("FAIL midrst: got valid=%b data=%h busy=%b, want 0 00 1", r8_valid, r8_data, busy8);
    end
    rst = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
      if (r8_valid !== 1'b0) break;
    end while (busy8 === 1'b1 && n < 1000);
    idle();
    checks++;
    if (n != 256) begin
      failures++;
      $display("FAIL midrst_reclear: got %0d cycles busy, want 256", n);
    end
    r8_en = 1'b1; r8_addr = 8'd0; tick();
    checks++;
    if (r8_valid !== 1'b1 || r8_data !== 8'h00) begin
      failures++;
      $display("FAIL midrst_rd0: got valid=%b data=%h, want 1 00", r8_valid, r8_data);
    end
    r8_addr = 8'd1; tick();
    checks++;
    if (r8_valid !== 1'b1 || r8_data !== 8'h00) begin
      failures++;
      $display("FAIL midrst_rd1: got valid=%b data=%h, want 1 00", r8_valid, r8_data);
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_clear_readback();
    test_basic_rw();
    test_byte_enables();
    test_collision();
    test_out_of_range();
`ifdef MEMORY_DP_PARITY_EN
    test_parity();
`endif
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
